// File: rtl/hold_timer_pkg.sv
// Shared types for the hold_timer responder: one-hot state encoding and a
// width helper used to size the prescaler.
package hold_timer_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd1,
    COUNTING = 3'd2,
    DONE     = 3'd4
  } state_t;

  // $clog2 yields 0 for values <= 1, but a register needs at least one bit.
  function automatic int width_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/hold_timer_tick_gen.sv
// Prescaler for hold_timer: counts enabled cycles and emits a one-cycle tick
// every PRESCALE of them. clr_i takes priority over en_i.
module hold_timer_tick_gen
  import hold_timer_pkg::*;
#(
  parameter int PRESCALE = 1,
  parameter int PW       = width_min1(PRESCALE)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;

  assign tick_o = en_i && (pre_q == LAST);

  always_comb begin
    pre_d = pre_q;
    if (clr_i) begin
      pre_d = '0;
    end else if (en_i) begin
      pre_d = tick_o ? '0 : pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/hold_timer.sv
// Timer responder: after START, counts N prescaled ticks while BUSY, then
// holds READY until CLR. Outputs are registered so no input reaches them.
module hold_timer
  import hold_timer_pkg::*;
#(
  parameter int N        = 4,
  parameter int PRESCALE = 1,
  parameter int CW       = $clog2(N + 1),
  parameter int PW       = width_min1(PRESCALE)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          CLR,
  input  logic          START,
  output logic          READY,
  output logic          BUSY,
  output logic [CW-1:0] COUNT,
  output state_t        DBG_STATE
);

  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(N);

  state_t        state_q;
  logic          ready_q;
  logic          busy_q;
  logic [CW-1:0] count_q;
  logic          tick;
  logic          tick_clr;
  logic          tick_en;

  // The prescaler restarts from zero both on CLR and when a run begins.
  assign tick_clr = CLR || ((state_q == IDLE) && START);
  assign tick_en  = (state_q == COUNTING);

  hold_timer_tick_gen #(
    .PRESCALE (PRESCALE),
    .PW       (PW)
  ) u_tick_gen (
    .clk_i  (CLK),
    .rst_i  (RESET),
    .clr_i  (tick_clr),
    .en_i   (tick_en),
    .tick_o (tick)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      count_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (CLR) begin
      state_q <= IDLE;
      count_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (START) begin
            state_q <= COUNTING;
            count_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        COUNTING: begin
          if (tick) begin
            if (count_q == LAST_CNT) begin
              state_q <= DONE;
              count_q <= FULL_CNT;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              count_q <= count_q + CW'(1);
            end
          end
        end
        DONE: begin
          count_q <= FULL_CNT;
        end
        default: begin
          state_q <= IDLE;
          count_q <= '0;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign READY     = ready_q;
  assign BUSY      = busy_q;
  assign COUNT     = count_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_hold_timer.sv
// Scoreboard bench for hold_timer: two instances (N=4/PRESCALE=3 and N=1/PRESCALE=1)
// driven by shared directed and random stimulus, checked against an elapsed-time model.
module tb_hold_timer;

  localparam int W = 11;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       start;
  logic       rdy0, bsy0, rdy1, bsy1;
  logic [2:0] cnt0;
  logic [0:0] cnt1;
  logic [2:0] st0, st1;

  hold_timer #(.N(4), .PRESCALE(3)) u_dut (
    .CLK(clk), .RESET(rst), .CLR(clr), .START(start),
    .READY(rdy0), .BUSY(bsy0), .COUNT(cnt0), .DBG_STATE(st0)
  );

  hold_timer #(.N(1), .PRESCALE(1)) u_min (
    .CLK(clk), .RESET(rst), .CLR(clr), .START(start),
    .READY(rdy1), .BUSY(bsy1), .COUNT(cnt1), .DBG_STATE(st1)
  );

  always #5 clk = ~clk;

  int             n_checks = 0;
  int             n_pass   = 0;
  logic [W-1:0]   exp_q0[$];
  logic [W-1:0]   exp_q1[$];
  bit             running[2];
  int             elapsed[2];

  function automatic int n_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic int p_of(input int d);
    return (d == 0) ? 3 : 1;
  endfunction

  // Expected {state, READY, BUSY, COUNT} from edges elapsed since the start edge.
  function automatic logic [W-1:0] expect_of(input bit run, input int el, input int n, input int p);
    if (!run) return {3'd1, 2'b00, 6'd0};
    if (el >= n * p) return {3'd4, 2'b10, 6'(n)};
    return {3'd2, 2'b01, 6'(el / p)};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic drive(input bit r, input bit c, input bit s);
    @(negedge clk);
    rst   = r;
    clr   = c;
    start = s;
    for (int d = 0; d < 2; d++) begin
      if (r || c) running[d] = 1'b0;
      else if (!running[d]) begin
        if (s) begin
          running[d] = 1'b1;
          elapsed[d] = 0;
        end
      end else elapsed[d]++;
    end
    exp_q0.push_back(expect_of(running[0], elapsed[0], n_of(0), p_of(0)));
    exp_q1.push_back(expect_of(running[1], elapsed[1], n_of(1), p_of(1)));
    if (r) begin
      #1;
      check("async_reset_dut", {st0, rdy0, bsy0, 6'(cnt0)}, {3'd1, 2'b00, 6'd0});
      check("async_reset_min", {st1, rdy1, bsy1, 6'(cnt1)}, {3'd1, 2'b00, 6'd0});
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    if (exp_q0.size() > 0) check("dut_outputs", {st0, rdy0, bsy0, 6'(cnt0)}, exp_q0.pop_front());
  end

  always begin
    @(posedge clk);
    #1;
    if (exp_q1.size() > 0) check("min_outputs", {st1, rdy1, bsy1, 6'(cnt1)}, exp_q1.pop_front());
  end

  initial begin
    rst   = 1'b1;
    clr   = 1'b0;
    start = 1'b0;
    running[0] = 1'b0;
    running[1] = 1'b0;
    elapsed[0] = 0;
    elapsed[1] = 0;

    drive(1, 0, 0);
    drive(1, 0, 0);

    // basic run
    drive(0, 0, 1);
    repeat (14) drive(0, 0, 0);
    drive(0, 1, 0);

    // clear mid-run, then restart one edge later
    drive(0, 0, 1);
    repeat (6) drive(0, 0, 0);
    drive(0, 1, 0);
    drive(0, 0, 1);
    repeat (14) drive(0, 0, 0);
    drive(0, 1, 0);

    // CLR beats START
    drive(0, 1, 1);
    repeat (3) drive(0, 0, 0);

    // START re-pulsed while counting and while done
    drive(0, 0, 1);
    for (int i = 0; i < 16; i++) drive(0, 0, (i % 3) == 1);
    drive(0, 1, 0);

    // START held high gives a single run
    repeat (20) drive(0, 0, 1);
    drive(0, 1, 0);

    // RESET mid-run, START right after release
    drive(0, 0, 1);
    repeat (5) drive(0, 0, 0);
    drive(1, 0, 0);
    drive(0, 0, 1);
    repeat (14) drive(0, 0, 0);

    // reset while DONE
    drive(1, 0, 0);
    drive(0, 0, 0);

    repeat (500) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0);
    end

    drive(0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    check("queue_drained", W'(exp_q0.size() + exp_q1.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
